// File: rtl/wt_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller with single-word lines.
// Optional read hit/miss statistics counters are enabled with WT_CACHE_STATS_EN.
module wt_cache_ctrl #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned NUM_LINES  = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] cpu_addr_in,
   input  logic [DATA_WIDTH-1:0] cpu_data_in,
   input  logic                  cpu_read_en,
   input  logic                  cpu_write_en,
   output logic [DATA_WIDTH-1:0] cpu_data_out,
   output logic                  cpu_ready,
   input  logic                  flush,
   output logic [ADDR_WIDTH-1:0] mem_addr_out,
   output logic [DATA_WIDTH-1:0] mem_data_out,
   output logic                  mem_read_en,
   output logic                  mem_write_en,
   input  logic [DATA_WIDTH-1:0] mem_data_in,
   input  logic                  mem_ready
`ifdef WT_CACHE_STATS_EN
   ,
   output logic [15:0]           read_hit_count,
   output logic [15:0]           read_miss_count
`endif
);
   localparam int unsigned IDX_W = $clog2(NUM_LINES);
   localparam int unsigned TAG_W = ADDR_WIDTH - IDX_W;

   typedef enum logic [1:0] {IDLE, MISS_RD, WR_THRU} state_t;

   state_t                r_state;
   logic [NUM_LINES-1:0]  r_valid;
   logic [TAG_W-1:0]      r_tag  [NUM_LINES];
   logic [DATA_WIDTH-1:0] r_data [NUM_LINES];
   logic                  r_flush_pend;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic                  r_ready;
   logic                  r_mem_rd;
   logic                  r_mem_wr;
`ifdef WT_CACHE_STATS_EN
   logic [15:0]           r_hit_cnt;
   logic [15:0]           r_miss_cnt;
`endif

   logic [IDX_W-1:0] w_idx;
   logic [TAG_W-1:0] w_tag;
   logic [IDX_W-1:0] w_lat_idx;
   logic [TAG_W-1:0] w_lat_tag;
   logic             w_req_hit;
   logic             w_lat_hit;
   logic             w_flush_now;

   assign w_idx       = cpu_addr_in[IDX_W-1:0];
   assign w_tag       = cpu_addr_in[ADDR_WIDTH-1:IDX_W];
   assign w_lat_idx   = r_addr[IDX_W-1:0];
   assign w_lat_tag   = r_addr[ADDR_WIDTH-1:IDX_W];
   // A flush in the same cycle as a request makes that request see an empty cache.
   assign w_req_hit   = r_valid[w_idx] && !flush && (r_tag[w_idx] == w_tag);
   assign w_lat_hit   = r_valid[w_lat_idx] && (r_tag[w_lat_idx] == w_lat_tag);
   assign w_flush_now = flush || r_flush_pend;

   assign cpu_data_out = r_rdata;
   assign cpu_ready    = r_ready;
   assign mem_addr_out = r_addr;
   assign mem_data_out = r_wdata;
   assign mem_read_en  = r_mem_rd;
   assign mem_write_en = r_mem_wr;
`ifdef WT_CACHE_STATS_EN
   assign read_hit_count  = r_hit_cnt;
   assign read_miss_count = r_miss_cnt;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= IDLE;
         r_valid      <= '0;
         r_flush_pend <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_rdata      <= '0;
         r_ready      <= 1'b0;
         r_mem_rd     <= 1'b0;
         r_mem_wr     <= 1'b0;
`ifdef WT_CACHE_STATS_EN
         r_hit_cnt    <= '0;
         r_miss_cnt   <= '0;
`endif
      end else begin
         r_ready <= 1'b0;
         case (r_state)
            IDLE: begin
               if (flush) r_valid <= '0;
               if (cpu_write_en) begin
                  r_addr   <= cpu_addr_in;
                  r_wdata  <= cpu_data_in;
                  r_mem_wr <= 1'b1;
                  r_state  <= WR_THRU;
               end else if (cpu_read_en) begin
                  r_addr  <= cpu_addr_in;
                  r_wdata <= cpu_data_in;
                  if (w_req_hit) begin
                     r_ready <= 1'b1;
                     r_rdata <= r_data[w_idx];
`ifdef WT_CACHE_STATS_EN
                     if (r_hit_cnt != 16'hFFFF) r_hit_cnt <= r_hit_cnt + 16'd1;
`endif
                  end else begin
                     r_mem_rd <= 1'b1;
                     r_state  <= MISS_RD;
                  end
               end
            end
            MISS_RD: begin
               if (flush) r_flush_pend <= 1'b1;
               if (mem_ready) begin
                  r_mem_rd <= 1'b0;
                  r_ready  <= 1'b1;
                  r_rdata  <= mem_data_in;
                  r_state  <= IDLE;
`ifdef WT_CACHE_STATS_EN
                  if (r_miss_cnt != 16'hFFFF) r_miss_cnt <= r_miss_cnt + 16'd1;
`endif
                  // Deferred flush also discards the line just filled.
                  if (w_flush_now) begin
                     r_valid      <= '0;
                     r_flush_pend <= 1'b0;
                  end else begin
                     r_valid[w_lat_idx] <= 1'b1;
                  end
               end
            end
            WR_THRU: begin
               if (flush) r_flush_pend <= 1'b1;
               if (mem_ready) begin
                  r_mem_wr <= 1'b0;
                  r_ready  <= 1'b1;
                  r_state  <= IDLE;
                  if (w_flush_now) begin
                     r_valid      <= '0;
                     r_flush_pend <= 1'b0;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (r_state == MISS_RD && mem_ready) begin
         r_tag[w_lat_idx]  <= w_lat_tag;
         r_data[w_lat_idx] <= mem_data_in;
      end else if (r_state == WR_THRU && mem_ready && w_lat_hit) begin
         r_data[w_lat_idx] <= r_wdata;
      end
   end
endmodule
